// File: rtl/wb_serializer_fifo_pkg.sv
// Shared constants and types for the Wishbone serializer with TX FIFO.
// Register addresses, CTRL/STAT bit positions and the shift-core state type.
package wb_serializer_fifo_pkg;

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_CTRL = 2'd1;
    localparam logic [1:0] ADR_STAT = 2'd2;

    localparam int CTRL_MSB_BIT    = 16;
    localparam int CTRL_EN_BIT     = 17;
    localparam int CTRL_IRQ_EN_BIT = 18;

    localparam int STAT_EMPTY_BIT  = 8;
    localparam int STAT_FULL_BIT   = 9;
    localparam int STAT_BUSY_BIT   = 10;
    localparam int STAT_OVF_BIT    = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } core_state_e;

endpackage

// File: rtl/wb_serializer_fifo_shift_core.sv
// Shift core: holds each bit for div+1 clocks, shifts a word out and
// chains straight into the next FIFO word when one is waiting.
//
//   state | meaning
//   IDLE  | nothing shifting, data_o low; pops head when enabled and FIFO not empty
//   SHIFT | word in flight; cnt_q counts down the bit period, idx_q is the bit index
module ser_shift_core
    import wb_serializer_fifo_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter int DIV_W  = 16
) (
    input  logic              CLK_I,
    input  logic              RST_NEWFREQ_I,
    input  logic              en_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] head_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              msb_first_i,
    output logic              pop_o,
    output logic              data_o,
    output logic              busy_o,
    output logic              eot_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    core_state_e       state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              msb_q, msb_d;
    logic              start;

    assign start = en_i & ~empty_i;

    always_ff @(posedge CLK_I or posedge RST_NEWFREQ_I) begin
        if (RST_NEWFREQ_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            msb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            msb_q   <= msb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        msb_d   = msb_q;
        pop_o   = 1'b0;
        eot_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pop_o   = 1'b1;
                    state_d = SHIFT;
                    shreg_d = head_i;
                    msb_d   = msb_first_i;
                    cnt_d   = div_i;
                    idx_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    eot_o = 1'b1;
                    if (start) begin
                        // Back-to-back: load the next word in the eot cycle, no idle gap.
                        pop_o   = 1'b1;
                        shreg_d = head_i;
                        msb_d   = msb_first_i;
                        cnt_d   = div_i;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = div_i;
                    shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign data_o = (state_q == SHIFT) & (msb_q ? shreg_q[DATA_W-1] : shreg_q[0]);

endmodule

// File: rtl/wb_serializer_fifo.sv
// Wishbone slave front end: register decode, CTRL/STAT registers and the
// circular TX FIFO that feeds the shift core.
module wb_serializer_fifo
    import wb_serializer_fifo_pkg::*;
#(
    parameter int DATA_W     = 27,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic        CLK_I,
    input  logic        RST_NEWFREQ_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        data_o,
    output logic        busy_o,
    output logic        eot_o,
    output logic        irq_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic              req, rd_acc, wr_acc;
    logic [1:0]        adr;
    logic              adr_bad, push_rej, push, pop;
    logic              empty, full, core_busy;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              msb_first_q, msb_first_d;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        level_q, level_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [31:0]       ctrl_rd, stat_rd;
    logic              unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_bits = ^{ADR_I[31:2], DAT_I};

    assign req      = CYC_I & STB_I;
    assign rd_acc   = req & ~WE_I;
    assign wr_acc   = req & WE_I;
    assign adr      = ADR_I[1:0];
    assign adr_bad  = (adr != ADR_DATA) && (adr != ADR_CTRL) && (adr != ADR_STAT);
    assign empty    = (level_q == 8'd0);
    assign full     = (level_q == 8'(FIFO_DEPTH));
    // Full is judged before this cycle's pop, so a same-cycle pop never rescues a push.
    assign push_rej = wr_acc & (adr == ADR_DATA) & full;
    assign push     = wr_acc & (adr == ADR_DATA) & ~full;
    assign ERR_O    = req & (adr_bad | push_rej);
    assign ACK_O    = req & ~(adr_bad | push_rej);

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[DIV_W-1:0]       = div_q;
        ctrl_rd[CTRL_MSB_BIT]    = msb_first_q;
        ctrl_rd[CTRL_EN_BIT]     = en_q;
        ctrl_rd[CTRL_IRQ_EN_BIT] = irq_en_q;
        stat_rd                  = '0;
        stat_rd[7:0]             = level_q;
        stat_rd[STAT_EMPTY_BIT]  = empty;
        stat_rd[STAT_FULL_BIT]   = full;
        stat_rd[STAT_BUSY_BIT]   = core_busy;
        stat_rd[STAT_OVF_BIT]    = ovf_q;
        DAT_O = '0;
        if (rd_acc && adr == ADR_CTRL) DAT_O = ctrl_rd;
        if (rd_acc && adr == ADR_STAT) DAT_O = stat_rd;
    end

    always_comb begin
        div_d       = div_q;
        msb_first_d = msb_first_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        ovf_d       = ovf_q;
        if (wr_acc && adr == ADR_CTRL) begin
            div_d       = DAT_I[DIV_W-1:0];
            msb_first_d = DAT_I[CTRL_MSB_BIT];
            en_d        = DAT_I[CTRL_EN_BIT];
            irq_en_d    = DAT_I[CTRL_IRQ_EN_BIT];
        end
        if (push_rej) begin
            ovf_d = 1'b1;
        end else if (wr_acc && adr == ADR_STAT && DAT_I[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 8'd1;
            2'b01:   level_d = level_q - 8'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_NEWFREQ_I) begin
        if (RST_NEWFREQ_I) begin
            div_q       <= '0;
            msb_first_q <= 1'b1;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            div_q       <= div_d;
            msb_first_q <= msb_first_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_ptr_q] <= DAT_I[DATA_W-1:0];
    end

    ser_shift_core #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_core (
        .CLK_I         (CLK_I),
        .RST_NEWFREQ_I (RST_NEWFREQ_I),
        .en_i          (en_q),
        .empty_i       (empty),
        .head_i        (mem_q[rd_ptr_q]),
        .div_i         (div_q),
        .msb_first_i   (msb_first_q),
        .pop_o         (pop),
        .data_o        (data_o),
        .busy_o        (core_busy),
        .eot_o         (eot_o)
    );

    assign busy_o = core_busy;
    assign irq_o  = irq_en_q & empty & ~core_busy;

endmodule

// File: tb/tb_wb_serializer_fifo.sv
// Self-checking bench for wb_serializer_fifo: bus decode, serial stream
// against a word-level reference, overflow, back-to-back, irq and reset.
module tb_wb_serializer_fifo;

    localparam int DW    = 27;
    localparam int DEPTH = 8;
    localparam int DIVW  = 16;

    logic        CLK_I = 1'b0;
    logic        RST_NEWFREQ_I;
    logic        CYC_I, STB_I, WE_I;
    logic [31:0] ADR_I, DAT_I;
    logic        ACK_O, ERR_O;
    logic [31:0] DAT_O;
    logic        data_o, busy_o, eot_o, irq_o;

    int checks = 0;
    int errors = 0;

    logic rec = 1'b0;
    logic tr_d[$], tr_b[$], tr_e[$];
    logic ex_d[$], ex_b[$], ex_e[$];

    logic        b_ack, b_err;
    logic [31:0] b_dat;

    wb_serializer_fifo #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIVW)
    ) dut (
        .CLK_I         (CLK_I),
        .RST_NEWFREQ_I (RST_NEWFREQ_I),
        .CYC_I         (CYC_I),
        .STB_I         (STB_I),
        .WE_I          (WE_I),
        .ADR_I         (ADR_I),
        .DAT_I         (DAT_I),
        .ACK_O         (ACK_O),
        .ERR_O         (ERR_O),
        .DAT_O         (DAT_O),
        .data_o        (data_o),
        .busy_o        (busy_o),
        .eot_o         (eot_o),
        .irq_o         (irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    always @(negedge CLK_I) begin
        if (rec) begin
            tr_d.push_back(data_o);
            tr_b.push_back(busy_o);
            tr_e.push_back(eot_o);
        end
    end

    // One single-cycle Wishbone access; response sampled mid-cycle.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
        #1;
        b_ack = ACK_O; b_err = ERR_O; b_dat = DAT_O;
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            ex_d.push_back(1'b0); ex_b.push_back(1'b0); ex_e.push_back(1'b0);
        end
    endtask

    // Trace index 0 is the cycle of the next bus access; the word is popped one
    // cycle later, so the first data bit is expected at index 2.
    task automatic start_trace();
        tr_d.delete(); tr_b.delete(); tr_e.delete();
        ex_d.delete(); ex_b.delete(); ex_e.delete();
        push_idle(2);
        rec = 1'b1;
    endtask

    task automatic expect_word(input logic [DW-1:0] w, input int div, input bit msb);
        int len;
        int b;
        len = DW * (div + 1);
        for (int k = 0; k < len; k++) begin
            b = k / (div + 1);
            ex_d.push_back(w[msb ? (DW - 1 - b) : b]);
            ex_b.push_back(1'b1);
            ex_e.push_back(k == len - 1);
        end
    endtask

    task automatic finish_trace(input string name, input int tail);
        int guard;
        int bd, bb, be, fd, fb, fe;
        push_idle(tail);
        guard = 0;
        while (tr_b.size() < ex_b.size() && guard < 20000) begin
            @(posedge CLK_I);
            guard++;
        end
        rec = 1'b0;
        checks++;
        if (tr_b.size() < ex_b.size()) begin
            errors++;
            $display("FAIL %s trace length: got %0d expected %0d", name, tr_b.size(), ex_b.size());
        end else begin
            bd = 0; bb = 0; be = 0; fd = -1; fb = -1; fe = -1;
            for (int i = 0; i < ex_b.size(); i++) begin
                if (tr_d[i] !== ex_d[i]) begin bd++; if (fd < 0) fd = i; end
                if (tr_b[i] !== ex_b[i]) begin bb++; if (fb < 0) fb = i; end
                if (tr_e[i] !== ex_e[i]) begin be++; if (fe < 0) fe = i; end
            end
            checks += 2;
            if (bd != 0) begin
                errors++;
                $display("FAIL %s data_o: %0d bad cycles, first at %0d got %b expected %b",
                         name, bd, fd, tr_d[fd], ex_d[fd]);
            end
            if (bb != 0) begin
                errors++;
                $display("FAIL %s busy_o: %0d bad cycles, first at %0d got %b expected %b",
                         name, bb, fb, tr_b[fb], ex_b[fb]);
            end
            if (be != 0) begin
                errors++;
                $display("FAIL %s eot_o: %0d bad cycles, first at %0d got %b expected %b",
                         name, be, fe, tr_e[fe], ex_e[fe]);
            end
        end
    endtask

    task automatic check_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
        bus(1'b0, adr, 32'h0);
        checks++;
        if (b_ack !== 1'b1 || b_err !== 1'b0 || b_dat !== exp) begin
            errors++;
            $display("FAIL %s: got ack=%b err=%b dat=%h expected ack=1 err=0 dat=%h",
                     name, b_ack, b_err, b_dat, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK_I);
        checks++;
        if ({data_o, busy_o, eot_o, irq_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got data/busy/eot/irq=%b expected 0000",
                     {data_o, busy_o, eot_o, irq_o});
        end
        check_read("reset ctrl", 32'h1, 32'h0001_0000);
        check_read("reset stat", 32'h2, 32'h0000_0100);
    endtask

    task automatic test_bad_addr();
        @(negedge CLK_I);
        #1;
        checks++;
        if (ACK_O !== 1'b0 || ERR_O !== 1'b0) begin
            errors++;
            $display("FAIL no-req handshake: got ack=%b err=%b expected 0 0", ACK_O, ERR_O);
        end
        bus(1'b0, 32'h3, 32'h0);
        checks++;
        if (b_ack !== 1'b0 || b_err !== 1'b1 || b_dat !== 32'h0) begin
            errors++;
            $display("FAIL read adr3: got ack=%b err=%b dat=%h expected 0 1 0", b_ack, b_err, b_dat);
        end
        bus(1'b1, 32'h3, 32'hFFFF_FFFF);
        checks++;
        if (b_ack !== 1'b0 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL write adr3: got ack=%b err=%b expected 0 1", b_ack, b_err);
        end
        check_read("read data reg", 32'h0, 32'h0);
        check_read("aliased ctrl", 32'h105, 32'h0001_0000);
    endtask

    task automatic test_msb_basic();
        logic [DW-1:0] w;
        bus(1'b1, 32'h1, 32'h0003_0000);
        start_trace();
        bus(1'b1, 32'h0, 32'h05A5_A5A5);
        expect_word(27'h5A5A5A5, 0, 1'b1);
        finish_trace("msb div0", 3);
        check_read("stat after msb word", 32'h2, 32'h0000_0100);
        // msb_first changed mid-word must not affect the word in flight.
        w = DW'($urandom);
        start_trace();
        bus(1'b1, 32'h0, 32'(w));
        expect_word(w, 0, 1'b1);
        repeat (5) @(negedge CLK_I);
        bus(1'b1, 32'h1, 32'h0002_0000);
        finish_trace("msb sampled at load", 3);
    endtask

    task automatic test_lsb_div3();
        bus(1'b1, 32'h1, 32'h0002_0003);
        start_trace();
        bus(1'b1, 32'h0, 32'h0000_0001);
        expect_word(27'h1, 3, 1'b0);
        finish_trace("lsb div3", 4);
    endtask

    task automatic test_overflow();
        logic [DW-1:0] words[9];
        int acks;
        bus(1'b1, 32'h1, 32'h0001_0000);
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            words[i] = DW'($urandom);
            bus(1'b1, 32'h0, 32'(words[i]));
            if (i < 8 && b_ack === 1'b1 && b_err === 1'b0) acks++;
        end
        checks++;
        if (acks != 8) begin
            errors++;
            $display("FAIL fill acks: got %0d expected 8", acks);
        end
        checks++;
        if (b_ack !== 1'b0 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL push when full: got ack=%b err=%b expected 0 1", b_ack, b_err);
        end
        check_read("stat full+ovf", 32'h2, 32'h0000_0A08);
        bus(1'b1, 32'h2, 32'h0000_0800);
        check_read("stat ovf cleared", 32'h2, 32'h0000_0208);
        start_trace();
        bus(1'b1, 32'h1, 32'h0003_0000);
        for (int i = 0; i < 8; i++) expect_word(words[i], 0, 1'b1);
        finish_trace("drain 8 words", 3);
        check_read("stat drained", 32'h2, 32'h0000_0100);
    endtask

    task automatic test_back_to_back();
        int div, n;
        bit msb;
        logic [DW-1:0] w;
        string nm;
        int nak;
        for (int it = 0; it < 5; it++) begin
            div = (it == 0) ? 0 : int'($urandom_range(0, 2));
            msb = (it == 0) ? 1'b1 : bit'($urandom_range(0, 1));
            n   = (it == 0) ? 2 : int'($urandom_range(1, 4));
            bus(1'b1, 32'h1, 32'h0002_0000 | (msb ? 32'h0001_0000 : 32'h0) | 32'(div));
            start_trace();
            nak = 0;
            for (int j = 0; j < n; j++) begin
                w = DW'($urandom);
                bus(1'b1, 32'h0, 32'(w));
                if (b_ack !== 1'b1) nak++;
                expect_word(w, div, msb);
            end
            checks++;
            if (nak != 0) begin
                errors++;
                $display("FAIL b2b push ack iter %0d: got %0d missing acks expected 0", it, nak);
            end
            $sformat(nm, "b2b iter %0d div %0d msb %0d n %0d", it, div, msb, n);
            finish_trace(nm, 3);
        end
    endtask

    task automatic test_irq();
        bus(1'b1, 32'h1, 32'h0004_0000);
        @(negedge CLK_I);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq empty idle: got %b expected 1", irq_o);
        end
        bus(1'b1, 32'h0, 32'h0000_0055);
        @(negedge CLK_I);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq after push: got %b expected 0", irq_o);
        end
        bus(1'b1, 32'h1, 32'h0007_0000);
        repeat (5) @(negedge CLK_I);
        checks++;
        if (irq_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL irq while busy: got irq=%b busy=%b expected 0 1", irq_o, busy_o);
        end
        repeat (35) @(negedge CLK_I);
        checks++;
        if (irq_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL irq after drain: got irq=%b busy=%b expected 1 0", irq_o, busy_o);
        end
        bus(1'b1, 32'h1, 32'h0001_0000);
    endtask

    task automatic test_reset_mid();
        int bad;
        bus(1'b1, 32'h1, 32'h0001_0000);
        for (int i = 0; i < 4; i++) bus(1'b1, 32'h0, $urandom);
        bus(1'b1, 32'h1, 32'h0003_0000);
        repeat (10) @(negedge CLK_I);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid-word busy: got %b expected 1", busy_o);
        end
        check_read("stat mid-word", 32'h2, 32'h0000_0403);
        @(negedge CLK_I);
        #2 RST_NEWFREQ_I = 1'b1;
        #1;
        checks++;
        if ({data_o, busy_o, eot_o} !== 3'b000) begin
            errors++;
            $display("FAIL async reset outputs: got data/busy/eot=%b expected 000",
                     {data_o, busy_o, eot_o});
        end
        @(posedge CLK_I);
        @(negedge CLK_I);
        RST_NEWFREQ_I = 1'b0;
        check_read("stat after reset", 32'h2, 32'h0000_0100);
        check_read("ctrl after reset", 32'h1, 32'h0001_0000);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_I);
            if (eot_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL activity after reset: got %0d busy/eot cycles expected 0", bad);
        end
    endtask

    initial begin
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
        RST_NEWFREQ_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        RST_NEWFREQ_I = 1'b0;
        test_reset();
        test_bad_addr();
        test_msb_basic();
        test_lsb_div3();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
